expu_correction_unit: RTL and testbench

Registered mantissa-correction stage of the exponential unit (EXPU). It takes the fractional part x ∈ [0,1) of a base-2 exponent and returns an approximation of 2^x − 1 on the same fixed-point grid. The approximation is a two-segment, multiply-light polynomial. It sits between the exponent/fraction split and the output packer, which attaches the corrected mantissa to the integer exponent.

---
 rtl/expu_pkg.sv | 47 ++++
 rtl/expu_correction_poly.sv | 111 +++++++++++
 rtl/expu_correction_unit.sv | 113 +++++++++++
 tb/tb_expu_correction_unit.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/expu_pkg.sv
// -----------------------------------------------------------------------------
// expu_pkg
//
// Shared definitions for the EXPU mantissa-correction stage.
//   - Default fraction widths of the fixed-point grids.
//   - Real-valued reference constants (beta, gamma1, gamma2) of the
//     two-segment approximation of 2^x - 1.
//   - quantize(): round-to-nearest of a real onto a given fraction width,
//     evaluated at elaboration time to produce the integer constants.
//   - max_int(): small helper for width arithmetic.
// -----------------------------------------------------------------------------
package expu_pkg;

  // Default fraction widths
  localparam int INPUT_FRACTION_DEF       = 7;
  localparam int COEFFICIENT_FRACTION_DEF = 4;
  localparam int CONSTANT_FRACTION_DEF    = 7;
  localparam int MUL_SURPLUS_BITS_DEF     = 1;
  localparam int NOT_SURPLUS_BITS_DEF     = 0;

  // Reference constants of the polynomial
  localparam real BETA_REAL   = 0.4375;    // 7/16
  localparam real GAMMA1_REAL = 3.296875;
  localparam real GAMMA2_REAL = 2.171875;

  // Segment select encoding (MSB of the fraction)
  typedef enum logic {
    SEG_LOW  = 1'b0,   // x <  0.5
    SEG_HIGH = 1'b1    // x >= 0.5
  } expu_seg_e;

  // Round a non-negative real to nearest on a grid with 'frac' fraction bits.
  // Returns the integer code (value * 2^frac).
  function automatic int quantize(input real value, input int frac);
    real scale;
    scale = 1.0;
    for (int i = 0; i < frac; i++) begin
      scale = scale * 2.0;
    end
    return $rtoi(value * scale + 0.5);
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/expu_correction_poly.sv
// -----------------------------------------------------------------------------
// expu_correction_poly
//
// Combinational two-segment approximation of 2^x - 1, x in [0,1).
// The datapath is split into a front end (fraction -> q, segment) and a back
// end (q, segment -> result) so the parent can optionally register between
// them without changing the arithmetic.
//
// Ports:
//   mantissa_i [IF-1:0]  fraction x (Q0.IF)
//   q_o        [W+1:0]   beta * p, Q2.W (W = IF + MUL_SURPLUS_BITS)
//   seg_o                segment of x (MSB of x)
//   q_i        [W+1:0]   q fed back from the parent (direct or registered)
//   seg_i                segment matching q_i
//   result_o   [IF-1:0]  corrected mantissa, Q0.IF
// -----------------------------------------------------------------------------
module expu_correction_poly
  import expu_pkg::*;
#(
  parameter int INPUT_FRACTION       = INPUT_FRACTION_DEF,
  parameter int COEFFICIENT_FRACTION = COEFFICIENT_FRACTION_DEF,
  parameter int CONSTANT_FRACTION    = CONSTANT_FRACTION_DEF,
  parameter int MUL_SURPLUS_BITS     = MUL_SURPLUS_BITS_DEF,
  parameter int NOT_SURPLUS_BITS     = NOT_SURPLUS_BITS_DEF,
  localparam int W  = INPUT_FRACTION + MUL_SURPLUS_BITS,
  localparam int QW = W + 2
) (
  input  logic [INPUT_FRACTION-1:0] mantissa_i,
  output logic [QW-1:0]             q_o,
  output logic                      seg_o,
  input  logic [QW-1:0]             q_i,
  input  logic                      seg_i,
  output logic [INPUT_FRACTION-1:0] result_o
);

  localparam int IF = INPUT_FRACTION;
  localparam int NS = NOT_SURPLUS_BITS;
  localparam int MS = MUL_SURPLUS_BITS;
  localparam int CF = COEFFICIENT_FRACTION;

  // s is formed on a common grid wide enough for both x and the gammas.
  localparam int SF = max_int(IF, CONSTANT_FRACTION);
  localparam int SW = SF + 2;          // s < 4 in both segments
  // Multiplier operand a carries NS extra fraction bits (NOT-domain grid).
  localparam int AW = IF + NS;
  localparam int MW = AW + SW;         // full product width
  localparam int QM = QW + CF;         // beta product width

  localparam int G1   = quantize(GAMMA1_REAL, CONSTANT_FRACTION);
  localparam int G2   = quantize(GAMMA2_REAL, CONSTANT_FRACTION);
  localparam int BETA = quantize(BETA_REAL, CF);

  // ---------------------------------------------------------------------------
  // Front end
  // ---------------------------------------------------------------------------
  logic [SW-1:0] x_al;
  logic [SW-1:0] g1_al;
  logic [SW-1:0] g2_al;
  logic [SW-1:0] s_sel;
  logic [AW-1:0] x_sh;
  logic [AW-1:0] a_sel;
  logic [MW-1:0] prod;
  logic [QW-1:0] p;
  logic [QM-1:0] q_prod;
  logic          seg;

  assign seg   = mantissa_i[IF-1];
  assign x_al  = SW'(mantissa_i) << (SF - IF);
  assign g1_al = SW'(G1) << (SF - CONSTANT_FRACTION);
  assign g2_al = SW'(G2) << (SF - CONSTANT_FRACTION);
  assign s_sel = (seg == SEG_HIGH) ? (x_al + g2_al) : (x_al + g1_al);

  // Segment 1 multiplies by x, segment 2 by NOT(x): both expressed on the
  // same Q0.(IF+NS) grid so one multiplier and one truncation serve both.
  // Inverting the zero-extended x sets the NS low bits, giving 1 - x - ulp.
  assign x_sh  = AW'(mantissa_i) << NS;
  assign a_sel = (seg == SEG_HIGH) ? ~x_sh : x_sh;

  assign prod   = MW'(a_sel) * MW'(s_sel);
  assign p      = QW'(prod >> (AW + SF - W));
  assign q_prod = QM'(p) * QM'(BETA);

  assign q_o   = QW'(q_prod >> CF);
  assign seg_o = seg;

  // ---------------------------------------------------------------------------
  // Back end
  // ---------------------------------------------------------------------------
  logic [IF-1:0] r_low;
  logic [AW-1:0] q_trunc;
  logic [AW-1:0] q_inv;
  logic [IF-1:0] r_high;

  // Segment 1: q/2 truncated to IF bits, i.e. drop MS+1 fraction bits.
  assign r_low = IF'(q_i >> (MS + 1));

  // Segment 2: truncate q to IF+NS fraction bits, invert, keep top IF bits.
  generate
    if (MS >= NS) begin : g_trunc_down
      assign q_trunc = AW'(q_i >> (MS - NS));
    end else begin : g_trunc_up
      assign q_trunc = AW'(q_i << (NS - MS));
    end
  endgenerate

  assign q_inv  = ~q_trunc;
  assign r_high = IF'(q_inv >> NS);

  assign result_o = (seg_i == SEG_HIGH) ? r_high : r_low;

endmodule

// File: rtl/expu_correction_unit.sv
// -----------------------------------------------------------------------------
// expu_correction_unit
//
// Registered mantissa-correction stage of the EXPU: returns an approximation
// of 2^x - 1 for the fraction x on the same Q0.INPUT_FRACTION grid.
//
// Build option:
//   EXPU_CORRECTION_PIPE_EN  defined   -> extra register after q, latency 2
//                            undefined -> single output register, latency 1
//   Numerical results are identical in both builds.
//
// Ports:
//   clk_i                       clock, rising edge
//   rst_i                       synchronous active-high reset
//   valid_i                     mantissa_i valid this cycle
//   mantissa_i [IF-1:0]         fraction x
//   valid_o                     corrected_mantissa_o valid
//   corrected_mantissa_o [IF-1:0] approximation of 2^x - 1
//
// Data registers load only on their stage's valid and hold otherwise; reset
// clears every stage and dominates valid_i.
// -----------------------------------------------------------------------------
module expu_correction_unit
  import expu_pkg::*;
#(
  parameter int INPUT_FRACTION       = INPUT_FRACTION_DEF,
  parameter int COEFFICIENT_FRACTION = COEFFICIENT_FRACTION_DEF,
  parameter int CONSTANT_FRACTION    = CONSTANT_FRACTION_DEF,
  parameter int MUL_SURPLUS_BITS     = MUL_SURPLUS_BITS_DEF,
  parameter int NOT_SURPLUS_BITS     = NOT_SURPLUS_BITS_DEF
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      valid_i,
  input  logic [INPUT_FRACTION-1:0] mantissa_i,
  output logic                      valid_o,
  output logic [INPUT_FRACTION-1:0] corrected_mantissa_o
);

  localparam int W  = INPUT_FRACTION + MUL_SURPLUS_BITS;
  localparam int QW = W + 2;

  logic [QW-1:0]             q_front;
  logic                      seg_front;
  logic [QW-1:0]             q_back;
  logic                      seg_back;
  logic                      valid_back;
  logic [INPUT_FRACTION-1:0] result;

  expu_correction_poly #(
    .INPUT_FRACTION       (INPUT_FRACTION),
    .COEFFICIENT_FRACTION (COEFFICIENT_FRACTION),
    .CONSTANT_FRACTION    (CONSTANT_FRACTION),
    .MUL_SURPLUS_BITS     (MUL_SURPLUS_BITS),
    .NOT_SURPLUS_BITS     (NOT_SURPLUS_BITS)
  ) u_poly (
    .mantissa_i (mantissa_i),
    .q_o        (q_front),
    .seg_o      (seg_front),
    .q_i        (q_back),
    .seg_i      (seg_back),
    .result_o   (result)
  );

`ifdef EXPU_CORRECTION_PIPE_EN
  // Pipe stage between the multipliers and the shift/inversion back end.
  logic [QW-1:0] q_reg;
  logic          seg_reg;
  logic          pipe_valid_reg;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      q_reg          <= '0;
      seg_reg        <= 1'b0;
      pipe_valid_reg <= 1'b0;
    end else begin
      pipe_valid_reg <= valid_i;
      if (valid_i) begin
        q_reg   <= q_front;
        seg_reg <= seg_front;
      end
    end
  end

  assign q_back     = q_reg;
  assign seg_back   = seg_reg;
  assign valid_back = pipe_valid_reg;
`else
  assign q_back     = q_front;
  assign seg_back   = seg_front;
  assign valid_back = valid_i;
`endif

  // Output register
  logic                      valid_reg;
  logic [INPUT_FRACTION-1:0] corr_reg;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_reg <= 1'b0;
      corr_reg  <= '0;
    end else begin
      valid_reg <= valid_back;
      if (valid_back) begin
        corr_reg <= result;
      end
    end
  end

  assign valid_o              = valid_reg;
  assign corrected_mantissa_o = corr_reg;

endmodule

// File: tb/tb_expu_correction_unit.sv
// -----------------------------------------------------------------------------
// tb_expu_correction_unit
//
// Randomised and directed bench for expu_correction_unit at default widths.
// The reference model computes the polynomial with plain integer arithmetic
// (floor division), and a latency-deep scoreboard tracks valid and held data.
// -----------------------------------------------------------------------------
module tb_expu_correction_unit;

`ifdef EXPU_CORRECTION_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       valid_in;
  logic [6:0] mant;
  logic       valid_out;
  logic [6:0] corr;

  always #5 clk = ~clk;

  expu_correction_unit dut (
    .clk_i                (clk),
    .rst_i                (rst),
    .valid_i              (valid_in),
    .mantissa_i           (mant),
    .valid_o              (valid_out),
    .corrected_mantissa_o (corr)
  );

  int tests = 0;
  int fails = 0;

  // Scoreboard: inputs in flight, newest at index 0.
  bit         mv [LAT];
  int         mx [LAT];
  bit         exp_valid = 1'b0;
  logic [6:0] exp_data  = 7'd0;
  bit         capture   = 1'b0;
  int         cap_q[$];

  // Bit-exact reference: defaults IF=7, CF=4, KF=7, MS=1, NS=0, W=8.
  // gamma1 = 422/128, gamma2 = 278/128, beta = 7/16.
  function automatic int ref_corr(input int x);
    int s, a, p, q;
    if (x < 64) begin
      s = x + 422;            // x + gamma1, 7 fraction bits
      p = (x * s) / 64;       // 14 -> 8 fraction bits
      q = (7 * p) / 16;       // beta * p, 8 fraction bits
      return q / 4;           // q/2 on 9 bits -> 7 bits
    end else begin
      a = 127 - x;            // 1 - x - ulp
      s = x + 278;            // x + gamma2
      p = (a * s) / 64;
      q = (7 * p) / 16;
      return 127 - (q / 2);   // NOT of q truncated to 7 bits
    end
  endfunction

  // One clock: drive at negedge, check #1 after the rising edge.
  task automatic step(input bit r, input bit v, input int x);
    @(negedge clk);
    rst      = r;
    valid_in = v;
    mant     = x[6:0];
    @(posedge clk);
    #1;
    if (r) begin
      for (int i = 0; i < LAT; i++) begin
        mv[i] = 1'b0;
        mx[i] = 0;
      end
      exp_valid = 1'b0;
      exp_data  = 7'd0;
    end else begin
      for (int i = LAT - 1; i > 0; i--) begin
        mv[i] = mv[i-1];
        mx[i] = mx[i-1];
      end
      mv[0] = v;
      mx[0] = x;
      exp_valid = mv[LAT-1];
      if (exp_valid) exp_data = 7'(ref_corr(mx[LAT-1]));
    end
    tests++;
    if (valid_out !== exp_valid) begin
      fails++;
      $display("FAIL valid: got %b expected %b (rst=%0d v=%0d x=0x%02h)", valid_out, exp_valid, r, v, x);
    end
    tests++;
    if (corr !== exp_data) begin
      fails++;
      $display("FAIL data: got 0x%02h expected 0x%02h (rst=%0d v=%0d x=0x%02h)", corr, exp_data, r, v, x);
    end
    if (capture && valid_out === 1'b1) cap_q.push_back(int'(corr));
  endtask

  task automatic test_reset();
    int n;
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, int'($urandom_range(0, 127)));
    $display("[TB] reset hold: valid_o=%b out=0x%02h", valid_out, corr);
    step(1'b0, 1'b1, 32);
    n = 1;
    while (valid_out !== 1'b1 && n < 6) begin
      step(1'b0, 1'b0, 0);
      n++;
    end
    tests++;
    if (n !== LAT) begin
      fails++;
      $display("FAIL reset_latency: got %0d expected %0d", n, LAT);
    end
    $display("[TB] first valid after reset at %0d cycles", n);
  endtask

  task automatic test_points();
    int xs [7] = '{8'h00, 8'h01, 8'h20, 8'h3F, 8'h40, 8'h60, 8'h7F};
    int ys [7] = '{8'h00, 8'h00, 8'h18, 8'h34, 8'h36, 8'h58, 8'h7F};
    for (int k = 0; k < 7; k++) begin
      step(1'b0, 1'b1, xs[k]);
      for (int i = 1; i < LAT; i++) step(1'b0, 1'b0, 0);
      tests++;
      if (valid_out !== 1'b1 || int'(corr) !== ys[k]) begin
        fails++;
        $display("FAIL point: x=0x%02h got 0x%02h (valid %b) expected 0x%02h", xs[k], corr, valid_out, ys[k]);
      end
      $display("[TB] point x=0x%02h -> 0x%02h", xs[k], corr);
    end
  endtask

  task automatic test_sweep();
    int ideal, d;
    cap_q.delete();
    capture = 1'b1;
    for (int x = 0; x < 128; x++) step(1'b0, 1'b1, x);
    for (int i = 0; i < LAT; i++) step(1'b0, 1'b0, 0);
    capture = 1'b0;
    tests++;
    if (cap_q.size() !== 128) begin
      fails++;
      $display("FAIL sweep_count: got %0d expected 128", cap_q.size());
    end else begin
      for (int x = 0; x < 128; x++) begin
        if (x > 0) begin
          tests++;
          if (cap_q[x] < cap_q[x-1]) begin
            fails++;
            $display("FAIL monotonic: x=%0d got %0d after %0d", x, cap_q[x], cap_q[x-1]);
          end
        end
        ideal = $rtoi($floor(128.0 * ((2.0 ** (real'(x) / 128.0)) - 1.0)));
        d = cap_q[x] - ideal;
        tests++;
        if (d > 2 || d < -2) begin
          fails++;
          $display("FAIL accuracy: x=%0d got %0d ideal %0d", x, cap_q[x], ideal);
        end
      end
    end
    $display("[TB] sweep 0..127 captured %0d outputs", cap_q.size());
  endtask

  task automatic test_gaps();
    for (int i = 0; i < 24; i++) step(1'b0, bit'(i % 2 == 0), int'($urandom_range(0, 127)));
    for (int i = 0; i < 24; i++) step(1'b0, bit'((i % 4) < 2), int'($urandom_range(0, 127)));
    for (int i = 0; i < 24; i++) step(1'b0, bit'((i % 3) == 0), int'($urandom_range(0, 127)));
    $display("[TB] valid gap patterns done");
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) step(1'b0, bit'($urandom_range(0, 1)), int'($urandom_range(0, 127)));
    $display("[TB] random stream done");
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, int'($urandom_range(0, 127)));
    for (int i = 0; i < 2; i++) step(1'b1, 1'b1, int'($urandom_range(0, 127)));
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 0);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, int'($urandom_range(0, 127)));
    $display("[TB] mid-stream reset done");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 64; i++) step(1'b0, 1'b1, int'($urandom_range(0, 127)));
    for (int i = 0; i < LAT + 1; i++) step(1'b0, 1'b0, 0);
    $display("[TB] back-to-back stream done");
  endtask

  initial begin
    rst      = 1'b1;
    valid_in = 1'b0;
    mant     = 7'd0;
    test_reset();
    test_points();
    test_sweep();
    test_gaps();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
